cpu_fetch_issue: RTL and testbench

Instruction fetch producer for the RV32 pipeline. Issues sequential 32-bit instruction reads on the instruction bus, buffers returned words with their PCs in a small queue, and presents them downstream to the pre-decode stage over a valid/ready handshake. Jump redirects from execute flush all buffered and in-flight instructions and restart fetch at the new PC.

---
 rtl/cpu_fetch_issue.sv | 171 +++++++++++++++++
 tb/tb_cpu_fetch_issue.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch_issue.sv
// cpu_fetch_issue: RV32 instruction fetch producer.
// Issues sequential word reads on the instruction bus, buffers returned
// words with their PCs in a small queue and presents them downstream over a
// valid/ready handshake. A jump flushes everything buffered or in flight and
// restarts fetch at the target.
// Optional feature: define CPU_FETCH_BYPASS_EN to let a bus response load the
// output register directly when nothing older is waiting (one cycle less
// latency). Without it every response goes through the queue.
`timescale 1ns/1ps

module cpu_fetch_issue #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          QUEUE_DEPTH  = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_bus_request,
  output logic [31:0] o_bus_address,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_jump,
  input  logic [31:0] i_jump_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruction
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      addr_q, addr_d;

  logic [31:0]      qpc_q  [QUEUE_DEPTH];
  logic [31:0]      qins_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic             vld_q;
  logic [31:0]      opc_q, oins_q;

  logic [31:0]      jump_pc;
  logic [CNT_W:0]   occupancy;
  logic             space_ok, issue, rsp_keep, out_free, pop, bypass, push;

  // Word-align the redirect target; the low two bits are meaningless.
  assign jump_pc = i_jump_pc & 32'hFFFF_FFFC;

  // Queue plus output register must leave room for the response we request.
  assign occupancy = {1'b0, cnt_q} + {{CNT_W{1'b0}}, vld_q};
  assign space_ok  = (occupancy <= (CNT_W + 1)'(QUEUE_DEPTH));

  // A new request is never started under reset or in a redirect cycle, so
  // a fresh request always targets the current fetch PC.
  assign issue    = (state_q == ST_FETCH) && space_ok && !i_jump && !i_reset;
  assign rsp_keep = (state_q == ST_WAIT) && i_bus_ready && !i_jump;
  assign out_free = !vld_q || i_ready;
  assign pop      = out_free && (cnt_q != '0) && !i_jump;

`ifdef CPU_FETCH_BYPASS_EN
  assign bypass = rsp_keep && (cnt_q == '0) && out_free;
`else
  assign bypass = 1'b0;
`endif

  assign push = rsp_keep && !bypass;

  assign o_bus_request = !i_reset &&
                         ((state_q == ST_WAIT) || (state_q == ST_DISCARD) || issue);
  assign o_bus_address = (state_q == ST_FETCH) ? pc_q : addr_q;
  assign o_valid       = vld_q;
  assign o_pc          = opc_q;
  assign o_instruction = oins_q;

  // Next-state logic for the bus FSM, fetch PC and latched request address.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    case (state_q)
      ST_FETCH: begin
        if (issue) begin
          state_d = ST_WAIT;
          addr_d  = pc_q;
        end
      end
      ST_WAIT: begin
        if (i_bus_ready) begin
          state_d = ST_FETCH;
          if (!i_jump) pc_d = pc_q + 32'd4;
        end else if (i_jump) begin
          state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (i_bus_ready) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    if (i_jump) pc_d = jump_pc;
  end

  // Bus FSM and fetch PC registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_VECTOR;
      addr_q  <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_jump) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Queue storage: returned word tagged with the address it was fetched from.
  always_ff @(posedge i_clock) begin
    if (push) begin
      qpc_q[wr_ptr_q]  <= addr_q;
      qins_q[wr_ptr_q] <= i_bus_rdata;
    end
  end

  // Output register: refills from the queue head (or a bypassed response)
  // whenever it is empty or being consumed; holds otherwise.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      vld_q  <= 1'b0;
      opc_q  <= 32'd0;
      oins_q <= 32'd0;
    end else if (i_jump) begin
      vld_q <= 1'b0;
    end else if (out_free) begin
      if (pop) begin
        vld_q  <= 1'b1;
        opc_q  <= qpc_q[rd_ptr_q];
        oins_q <= qins_q[rd_ptr_q];
      end else if (bypass) begin
        vld_q  <= 1'b1;
        opc_q  <= addr_q;
        oins_q <= i_bus_rdata;
      end else begin
        vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_fetch_issue.sv
// Testbench for cpu_fetch_issue: bus slave and redirect stimulus with a
// reference model of the expected instruction stream; a separate monitor
// checks every delivered instruction against the model queue.
`timescale 1ns/1ps

module tb_cpu_fetch_issue;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int          QD = 4;

  logic        clk;
  logic        i_reset;
  logic        o_bus_request;
  logic [31:0] o_bus_address;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;
  logic        i_jump;
  logic [31:0] i_jump_pc;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_pc;
  logic [31:0] o_instruction;

  cpu_fetch_issue #(.RESET_VECTOR(RV), .QUEUE_DEPTH(QD)) dut (
    .i_clock       (clk),
    .i_reset       (i_reset),
    .o_bus_request (o_bus_request),
    .o_bus_address (o_bus_address),
    .i_bus_ready   (i_bus_ready),
    .i_bus_rdata   (i_bus_rdata),
    .i_jump        (i_jump),
    .i_jump_pc     (i_jump_pc),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_pc          (o_pc),
    .o_instruction (o_instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } item_t;

  item_t       sb[$];
  int          errors = 0;
  int          checks = 0;

  // Reference model / slave state
  bit          outstanding, stale, new_req, resp_fired, resp_kept;
  logic [31:0] req_addr, model_pc;
  int          delay, lat_min, lat_max, rdy_mode;

  // Monitor state
  bit          hold;
  logic [31:0] hold_pc, hold_ins;
  item_t       mon_e;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the edge, update the model with what
  // the bus and redirect do this cycle, then observe requests at the falling edge.
  task automatic drive(input bit jmp, input logic [31:0] jpc);
    bit was_out;
    @(posedge clk); #1;
    was_out     = outstanding;
    resp_fired  = 1'b0;
    resp_kept   = 1'b0;
    i_reset     = 1'b0;
    i_bus_ready = 1'b0;
    i_bus_rdata = $urandom;
    i_jump      = jmp;
    i_jump_pc   = jmp ? jpc : $urandom;
    if (outstanding) begin
      delay--;
      if (delay <= 0) begin
        i_bus_ready = 1'b1;
        i_bus_rdata = mem_word(req_addr);
        resp_fired  = 1'b1;
      end
    end
    case (rdy_mode)
      0:       i_ready = 1'b0;
      1:       i_ready = 1'b1;
      default: i_ready = 1'($urandom_range(0, 1));
    endcase
    if (jmp) i_ready = 1'b0;
    if (jmp) begin
      sb.delete();
      model_pc = jpc & ~32'h3;
      if (outstanding) begin
        if (resp_fired) begin
          outstanding = 1'b0;
          stale       = 1'b0;
        end else begin
          stale = 1'b1;
        end
      end
    end else if (resp_fired) begin
      if (!stale) begin
        sb.push_back('{pc: req_addr, ins: mem_word(req_addr)});
        model_pc  = model_pc + 32'd4;
        resp_kept = 1'b1;
      end
      outstanding = 1'b0;
      stale       = 1'b0;
    end
    @(negedge clk);
    new_req = 1'b0;
    if (!was_out) begin
      if (o_bus_request) begin
        new_req     = 1'b1;
        check_eq("req_addr", o_bus_address, model_pc);
        outstanding = 1'b1;
        stale       = 1'b0;
        req_addr    = o_bus_address;
        delay       = $urandom_range(lat_min, lat_max);
      end
    end else if (outstanding) begin
      check_eq("req_hold", {31'd0, o_bus_request}, 32'd1);
      check_eq("addr_stable", o_bus_address, req_addr);
    end
  endtask

  // Hold reset for n rising edges; ends at a falling edge with reset still high.
  task automatic do_reset(input int n);
    @(posedge clk); #1;
    i_reset     = 1'b1;
    i_jump      = 1'b0;
    i_bus_ready = 1'b0;
    i_ready     = 1'b0;
    sb.delete();
    outstanding = 1'b0;
    stale       = 1'b0;
    model_pc    = RV;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_new_req(input string name, input int bound);
    int n;
    n = 0;
    do begin
      drive(1'b0, 32'd0);
      n++;
    end while (!new_req && n < bound);
    check_eq(name, {31'd0, new_req}, 32'd1);
  endtask

  // Monitor: every transfer must match the model head; held outputs must not move.
  always @(negedge clk) begin
    if (i_reset) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check_eq("hold_valid", {31'd0, o_valid}, 32'd1);
        check_eq("hold_pc", o_pc, hold_pc);
        check_eq("hold_ins", o_instruction, hold_ins);
      end
      hold = 1'b0;
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pc %h expected no output", o_pc);
        end else begin
          mon_e = sb.pop_front();
          check_eq("out_pc", o_pc, mon_e.pc);
          check_eq("out_ins", o_instruction, mon_e.ins);
        end
      end else if (o_valid && !i_jump) begin
        hold     = 1'b1;
        hold_pc  = o_pc;
        hold_ins = o_instruction;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    i_reset     = 1'b1;
    i_bus_ready = 1'b0;
    i_bus_rdata = 32'd0;
    i_jump      = 1'b0;
    i_jump_pc   = 32'd0;
    i_ready     = 1'b0;
    rdy_mode    = 1;
    lat_min     = 1;
    lat_max     = 1;
    hold        = 1'b0;

    // Reset state
    do_reset(3);
    check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
    check_eq("rst_req", {31'd0, o_bus_request}, 32'd0);
    check_eq("rst_addr", o_bus_address, RV);
    check_eq("rst_pc", o_pc, 32'd0);
    check_eq("rst_ins", o_instruction, 32'd0);

    // Sequential fetch with a one-cycle slave and latency of first word
    drive(1'b0, 32'd0);
    check_eq("first_req", {31'd0, new_req}, 32'd1);
    n = 0;
    do begin
      drive(1'b0, 32'd0);
      n++;
    end while (!resp_kept && n < 10);
    check_eq("first_resp", {31'd0, resp_kept}, 32'd1);
    check_eq("lat_n", {31'd0, o_valid}, 32'd0);
    drive(1'b0, 32'd0);
`ifdef CPU_FETCH_BYPASS_EN
    check_eq("lat_n1", {31'd0, o_valid}, 32'd1);
`else
    check_eq("lat_n1", {31'd0, o_valid}, 32'd0);
    drive(1'b0, 32'd0);
    check_eq("lat_n2", {31'd0, o_valid}, 32'd1);
`endif
    repeat (12) drive(1'b0, 32'd0);

    // Downstream stall fills the buffer, then drains in order
    rdy_mode = 0;
    repeat (20) drive(1'b0, 32'd0);
    check_eq("full_noreq", {31'd0, o_bus_request}, 32'd0);
    check_eq("full_count", sb.size(), QD + 1);
    check_eq("full_valid", {31'd0, o_valid}, 32'd1);
    rdy_mode = 1;
    repeat (20) drive(1'b0, 32'd0);

    // Redirect while a request is outstanding
    lat_min = 4;
    lat_max = 4;
    wait_new_req("wait_req_t3", 20);
    drive(1'b0, 32'd0);
    drive(1'b1, 32'h0000_1003);
    lat_min = 1;
    lat_max = 1;
    wait_new_req("jump_req", 20);
    check_eq("jump_target_addr", req_addr, 32'h0000_1000);
    n = 0;
    do begin
      drive(1'b0, 32'd0);
      n++;
    end while (!o_valid && n < 20);
    check_eq("jump_first_pc", o_pc, 32'h0000_1000);
    repeat (6) drive(1'b0, 32'd0);

    // Redirect coincident with the bus response
    lat_min = 3;
    lat_max = 3;
    wait_new_req("wait_req_t4", 20);
    drive(1'b0, 32'd0);
    drive(1'b0, 32'd0);
    drive(1'b1, 32'h0000_2000);
    check_eq("coincide_ready", {31'd0, resp_fired}, 32'd1);
    lat_min = 1;
    lat_max = 1;
    drive(1'b0, 32'd0);
    check_eq("coincide_next_req", {31'd0, new_req}, 32'd1);
    check_eq("coincide_next_addr", req_addr, 32'h0000_2000);
    repeat (8) drive(1'b0, 32'd0);

    // Fetch PC wraps from the top of the address space
    drive(1'b1, 32'hFFFF_FFFC);
    wait_new_req("wrap_req0", 20);
    check_eq("wrap_top", req_addr, 32'hFFFF_FFFC);
    wait_new_req("wrap_req1", 20);
    check_eq("wrap_addr", req_addr, 32'h0000_0000);
    repeat (8) drive(1'b0, 32'd0);

    // Reset in the middle of a request with the buffer filling
    rdy_mode = 0;
    lat_min  = 6;
    lat_max  = 6;
    n = 0;
    do begin
      drive(1'b0, 32'd0);
      n++;
    end while (!(outstanding && sb.size() == QD) && n < 100);
    check_eq("midwait_reached", {31'd0, outstanding}, 32'd1);
    do_reset(1);
    check_eq("midrst_valid", {31'd0, o_valid}, 32'd0);
    check_eq("midrst_req", {31'd0, o_bus_request}, 32'd0);
    rdy_mode = 1;
    lat_min  = 1;
    lat_max  = 1;
    drive(1'b0, 32'd0);
    check_eq("restart_req", {31'd0, new_req}, 32'd1);
    check_eq("restart_addr", req_addr, RV);
    repeat (10) drive(1'b0, 32'd0);

    // Random traffic: slave latency, downstream stalls and redirects
    lat_min  = 1;
    lat_max  = 3;
    rdy_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 24) == 0, $urandom);
    end
    rdy_mode = 1;
    lat_min  = 1;
    lat_max  = 1;
    repeat (40) drive(1'b0, 32'd0);
    check_eq("drain_backlog", {31'd0, (sb.size() <= 2)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
